// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V subset control unit: one Moore FSM that sequences the datapath
// through fetch/decode/execute/memory/writeback, with a wait counter covering memory latency.
module uc_multiciclo #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic [6:0] FUNCT7,
  input  logic       ZERO,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_ALUOUT,
  output logic       MDR_LOAD,
  output logic       MEM_WRITE,
  output logic       BANCO_WRITE,
  output logic       RESET_WIRE,
  output logic       IORD,
  output logic       PC_SRC,
  output logic [1:0] ALU_SRCA,
  output logic [1:0] ALU_SRCB,
  output logic [1:0] MEM_TO_REG,
  output logic [2:0] ALU_SELECTOR,
  output logic       EXCEPTION,
  output logic [4:0] ESTADO_ATUAL
);

  typedef enum logic [4:0] {
    RESET_ST = 5'd0,
    FETCH    = 5'd1,
    DECODE   = 5'd2,
    EXEC_R   = 5'd3,
    EXEC_I   = 5'd4,
    ADDR     = 5'd5,
    MEM_RD   = 5'd6,
    MEM_WR   = 5'd7,
    WB_ALU   = 5'd8,
    WB_MEM   = 5'd9,
    BRANCH   = 5'd10,
    LUI      = 5'd11,
    JAL      = 5'd12,
    TRAP     = 5'd13
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             waiting;
  logic             r_ok;
  logic [2:0]       r_sel;

  assign last         = (cnt == LAST_CNT);
  assign waiting      = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign ESTADO_ATUAL = state;

  // R-type legality and ALU operation from funct7/funct3
  always_comb begin
    r_ok  = 1'b0;
    r_sel = 3'b001;
    case ({FUNCT7, FUNCT3})
      {7'b0000000, 3'b000}: begin r_ok = 1'b1; r_sel = 3'b001; end
      {7'b0100000, 3'b000}: begin r_ok = 1'b1; r_sel = 3'b010; end
      {7'b0000000, 3'b111}: begin r_ok = 1'b1; r_sel = 3'b011; end
      {7'b0000000, 3'b010}: begin r_ok = 1'b1; r_sel = 3'b111; end
      default:              begin r_ok = 1'b0; r_sel = 3'b001; end
    endcase
  end

  // Counter restarts whenever the state changes, so it is 0 on entry to every wait state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= RESET_ST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (waiting && (state_nx == state)) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nx     = state;
    PC_WRITE     = 1'b0;
    IR_WRITE     = 1'b0;
    LOAD_A       = 1'b0;
    LOAD_B       = 1'b0;
    LOAD_ALUOUT  = 1'b0;
    MDR_LOAD     = 1'b0;
    MEM_WRITE    = 1'b0;
    BANCO_WRITE  = 1'b0;
    RESET_WIRE   = 1'b0;
    IORD         = 1'b0;
    PC_SRC       = 1'b0;
    ALU_SRCA     = 2'd0;
    ALU_SRCB     = 2'd0;
    MEM_TO_REG   = 2'd0;
    ALU_SELECTOR = 3'b000;
    EXCEPTION    = 1'b0;
    case (state)
      RESET_ST: begin
        RESET_WIRE = 1'b1;
        state_nx   = FETCH;
      end
      FETCH: begin
        if (last) begin
          IR_WRITE     = 1'b1;
          ALU_SRCB     = 2'd1;
          ALU_SELECTOR = 3'b001;
          PC_WRITE     = 1'b1;
          state_nx     = DECODE;
        end
      end
      DECODE: begin
        // Branch target OLD_PC+IMM is precomputed into ALUOUT here
        LOAD_A       = 1'b1;
        LOAD_B       = 1'b1;
        ALU_SRCA     = 2'd2;
        ALU_SRCB     = 2'd2;
        ALU_SELECTOR = 3'b001;
        LOAD_ALUOUT  = 1'b1;
        case (OPCODE)
          OP_R:         state_nx = r_ok ? EXEC_R : TRAP;
          OP_I:         state_nx = (FUNCT3 == 3'b000) ? EXEC_I : TRAP;
          OP_LD, OP_SD: state_nx = (FUNCT3 == 3'b011) ? ADDR : TRAP;
          OP_BR:        state_nx = (FUNCT3 == 3'b000 || FUNCT3 == 3'b001) ? BRANCH : TRAP;
          OP_LUI:       state_nx = LUI;
          OP_JAL:       state_nx = JAL;
          default:      state_nx = TRAP;
        endcase
      end
      EXEC_R: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 2'd0;
        ALU_SELECTOR = r_sel;
        LOAD_ALUOUT  = 1'b1;
        state_nx     = WB_ALU;
      end
      EXEC_I: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 2'd2;
        ALU_SELECTOR = 3'b001;
        LOAD_ALUOUT  = 1'b1;
        state_nx     = WB_ALU;
      end
      WB_ALU: begin
        BANCO_WRITE = 1'b1;
        state_nx    = FETCH;
      end
      ADDR: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 2'd2;
        ALU_SELECTOR = 3'b001;
        LOAD_ALUOUT  = 1'b1;
        state_nx     = (OPCODE == OP_LD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        IORD = 1'b1;
        if (last) begin
          MDR_LOAD = 1'b1;
          state_nx = WB_MEM;
        end
      end
      WB_MEM: begin
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'd1;
        state_nx    = FETCH;
      end
      MEM_WR: begin
        IORD      = 1'b1;
        MEM_WRITE = 1'b1;
        if (last) state_nx = FETCH;
      end
      BRANCH: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 2'd0;
        ALU_SELECTOR = 3'b010;
        PC_SRC       = 1'b1;
        PC_WRITE     = (FUNCT3 == 3'b000) ? ZERO : ~ZERO;
        state_nx     = FETCH;
      end
      LUI: begin
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'd3;
        state_nx    = FETCH;
      end
      JAL: begin
        // PC still holds PC+4 this cycle, so the link value is written as it is replaced
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'd2;
        PC_SRC      = 1'b1;
        PC_WRITE    = 1'b1;
        state_nx    = FETCH;
      end
      TRAP: begin
        EXCEPTION = 1'b1;
      end
      default: state_nx = RESET_ST;
    endcase
  end

endmodule
